firebird7_in_gate1_tessent_tdr_data_ctrl: RTL and testbench

IJTAG test data register (TDR) that drives the select and data inputs of the gate1 W-bit IJTAG data mux.
- Captures the functional value the mux is overriding.
- Shifts it out on the IJTAG scan path and shifts in a new select/data word.
- Updates the mux controls only on a correctly-sized shift.
- Sits on the firebird7_in gate1 IJTAG network, between the SIB-controlled scan segment and the mux.

---
 rtl/firebird7_in_gate1_tessent_tdr_data_ctrl.sv | 115 +++++++++++
 tb/tb_firebird7_in_gate1_tessent_tdr_data_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_data_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : firebird7_in_gate1_tessent_tdr_data_ctrl
//  Purpose  : IJTAG TDR driving select/data of the gate1 data mux.
//             Optional macro FIREBIRD7_IN_TDR_ERR_CAPTURE_EN adds an error
//             status bit at the scan-out end of the chain.
//  Revision : 1.0 - initial release
// ============================================================================
module firebird7_in_gate1_tessent_tdr_data_ctrl #(
   parameter int WIDTH        = 3,
   parameter int CNT_W        = 4,
   parameter bit UPDATE_GUARD = 1'b1
) (
   input  logic             ijtag_tck,
   input  logic             ijtag_reset,
   input  logic             ijtag_sel,
   input  logic             ijtag_ce,
   input  logic             ijtag_se,
   input  logic             ijtag_ue,
   input  logic             ijtag_si,
   output logic             ijtag_so,
   input  logic [WIDTH-1:0] functional_data_in,
   output logic             ijtag_select,
   output logic [WIDTH-1:0] ijtag_data_out,
   output logic             shift_len_err
);

`ifdef FIREBIRD7_IN_TDR_ERR_CAPTURE_EN
   localparam int c_OFF = 1;
`else
   localparam int c_OFF = 0;
`endif
   localparam int               c_LEN     = WIDTH + 1 + c_OFF;
   localparam logic [CNT_W-1:0] c_LEN_CNT = CNT_W'(c_LEN);
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CAPTURED = 2'd1,
      SHIFTING = 2'd2
   } state_t;

   state_t             r_state,    w_state_nxt;
   logic [c_LEN-1:0]   r_shift,    w_shift_nxt;
   logic               r_upd_sel,  w_upd_sel_nxt;
   logic [WIDTH-1:0]   r_upd_data, w_upd_data_nxt;
   logic [CNT_W-1:0]   r_cnt,      w_cnt_nxt;
   logic               r_err,      w_err_nxt;
   logic               w_cap, w_shf, w_upd, w_legal;

   // One operation per cycle: capture beats shift beats update.
   assign w_cap   = ijtag_sel & ijtag_ce;
   assign w_shf   = ijtag_sel & ijtag_se & ~ijtag_ce;
   assign w_upd   = ijtag_sel & ijtag_ue & ~ijtag_ce & ~ijtag_se;
   assign w_legal = (r_state == SHIFTING) && (r_cnt == c_LEN_CNT);

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_upd_sel_nxt  = r_upd_sel;
      w_upd_data_nxt = r_upd_data;
      w_cnt_nxt      = r_cnt;
      w_err_nxt      = r_err;
      if (w_cap) begin
`ifdef FIREBIRD7_IN_TDR_ERR_CAPTURE_EN
         w_shift_nxt = {r_upd_sel, functional_data_in, r_err};
`else
         w_shift_nxt = {r_upd_sel, functional_data_in};
`endif
         w_cnt_nxt   = '0;
         w_state_nxt = CAPTURED;
      end else if (w_shf) begin
         w_shift_nxt = {ijtag_si, r_shift[c_LEN-1:1]};
         // Saturate so that very long shifts can never alias a legal count.
         if (r_cnt != c_CNT_MAX) begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
         w_state_nxt = SHIFTING;
      end else if (w_upd) begin
         if (w_legal || !UPDATE_GUARD) begin
            w_upd_sel_nxt  = r_shift[c_LEN-1];
            w_upd_data_nxt = r_shift[c_OFF +: WIDTH];
         end else begin
            w_err_nxt = 1'b1;
         end
         w_cnt_nxt   = '0;
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge ijtag_tck) begin
      if (ijtag_reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_upd_sel  <= 1'b0;
         r_upd_data <= '0;
         r_cnt      <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_upd_sel  <= w_upd_sel_nxt;
         r_upd_data <= w_upd_data_nxt;
         r_cnt      <= w_cnt_nxt;
         r_err      <= w_err_nxt;
      end
   end

   assign ijtag_so       = r_shift[0];
   assign ijtag_select   = r_upd_sel;
   assign ijtag_data_out = r_upd_data;
   assign shift_len_err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_firebird7_in_gate1_tessent_tdr_data_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_firebird7_in_gate1_tessent_tdr_data_ctrl
//  Purpose  : Directed + random bench with a queue-based scan-chain model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_firebird7_in_gate1_tessent_tdr_data_ctrl;

   localparam int WIDTH = 3;
   localparam int CNT_W = 4;
   localparam bit GUARD = 1'b1;
`ifdef FIREBIRD7_IN_TDR_ERR_CAPTURE_EN
   localparam int OFF = 1;
`else
   localparam int OFF = 0;
`endif
   localparam int L    = WIDTH + 1 + OFF;
   localparam int CMAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst, sel, ce, se, ue, si;
   logic [WIDTH-1:0] fdi;
   logic             so, osel, err;
   logic [WIDTH-1:0] odata;

   always #5 clk = ~clk;

   firebird7_in_gate1_tessent_tdr_data_ctrl #(
      .WIDTH       (WIDTH),
      .CNT_W       (CNT_W),
      .UPDATE_GUARD(GUARD)
   ) dut (
      .ijtag_tck         (clk),
      .ijtag_reset       (rst),
      .ijtag_sel         (sel),
      .ijtag_ce          (ce),
      .ijtag_se          (se),
      .ijtag_ue          (ue),
      .ijtag_si          (si),
      .ijtag_so          (so),
      .functional_data_in(fdi),
      .ijtag_select      (osel),
      .ijtag_data_out    (odata),
      .shift_len_err     (err)
   );

   // Model: chain as a queue, front element is what appears on scan-out.
   bit             m_q[$];
   bit             m_sel;
   bit [WIDTH-1:0] m_data;
   bit             m_err;
   int             m_cnt;
   int             m_phase;   // 0 idle, 1 captured, 2 shifting
   int             n_cmp = 0;
   int             n_bad = 0;

   task automatic model_reset();
      m_q.delete();
      for (int i = 0; i < L; i++) m_q.push_back(1'b0);
      m_sel = 1'b0; m_data = '0; m_err = 1'b0; m_cnt = 0; m_phase = 0;
   endtask

   task automatic model_step();
      if (rst) begin
         model_reset();
      end else if (sel && ce) begin
         m_q.delete();
         if (OFF == 1) m_q.push_back(m_err);
         for (int i = 0; i < WIDTH; i++) m_q.push_back(fdi[i]);
         m_q.push_back(m_sel);
         m_cnt = 0; m_phase = 1;
      end else if (sel && se) begin
         void'(m_q.pop_front());
         m_q.push_back(si);
         if (m_cnt < CMAX) m_cnt++;
         m_phase = 2;
      end else if (sel && ue) begin
         if ((m_phase == 2 && m_cnt == L) || !GUARD) begin
            m_sel = m_q[L-1];
            for (int i = 0; i < WIDTH; i++) m_data[i] = m_q[OFF + i];
         end else begin
            m_err = 1'b1;
         end
         m_cnt = 0; m_phase = 0;
      end
   endtask

   task automatic check(input string tag);
      n_cmp++;
      assert (so === m_q[0]) else begin
         n_bad++; $error("FAIL %s so: got %b expected %b", tag, so, m_q[0]);
      end
      n_cmp++;
      assert (osel === m_sel) else begin
         n_bad++; $error("FAIL %s select: got %b expected %b", tag, osel, m_sel);
      end
      n_cmp++;
      assert (odata === m_data) else begin
         n_bad++; $error("FAIL %s data: got %b expected %b", tag, odata, m_data);
      end
      n_cmp++;
      assert (err === m_err) else begin
         n_bad++; $error("FAIL %s err: got %b expected %b", tag, err, m_err);
      end
   endtask

   task automatic expect_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++; $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step(input string tag, input bit r, input bit s, input bit c,
                       input bit sh, input bit u, input bit i, input bit [WIDTH-1:0] f);
      rst = r; sel = s; ce = c; se = sh; ue = u; si = i; fdi = f;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check(tag);
   endtask

   task automatic do_rst(input string tag);   step(tag, 1, 0, 0, 0, 0, 0, '0); endtask
   task automatic do_cap(input string tag, input bit [WIDTH-1:0] f); step(tag, 0, 1, 1, 0, 0, 0, f); endtask
   task automatic do_shf(input string tag, input bit b); step(tag, 0, 1, 0, 1, 0, b, fdi); endtask
   task automatic do_upd(input string tag);   step(tag, 0, 1, 0, 0, 1, 0, fdi); endtask

   initial begin
      bit [L-1:0] word;
      int         n;
      model_reset();

      // Reset held two cycles.
      do_rst("rst0");
      do_rst("rst1");
      expect_val("rst_all_zero", {4'b0, so, osel, err, 1'b0} | 8'(odata), 8'h00);

      // Capture 101 and shift zeros out.
      do_cap("s2_cap", 3'b101);
`ifndef FIREBIRD7_IN_TDR_ERR_CAPTURE_EN
      expect_val("s2_so0", 8'(so), 8'd1);
`endif
      for (int k = 0; k < L; k++) begin
         do_shf("s2_shf", 1'b0);
`ifndef FIREBIRD7_IN_TDR_ERR_CAPTURE_EN
         if (k == 0) expect_val("s2_so1", 8'(so), 8'd0);
         if (k == 1) expect_val("s2_so2", 8'(so), 8'd1);
         if (k == 2) expect_val("s2_so3", 8'(so), 8'd0);
`endif
      end

      // Legal shift-update: select=1, data=110.
`ifdef FIREBIRD7_IN_TDR_ERR_CAPTURE_EN
      word = 5'b11100;
`else
      word = 4'b1110;
`endif
      do_cap("s3_cap", 3'b010);
      for (int k = 0; k < L; k++) do_shf("s3_shf", word[k]);
      do_upd("s3_upd");
      expect_val("s3_select", 8'(osel), 8'd1);
      expect_val("s3_data", 8'(odata), 8'h06);
      expect_val("s3_err", 8'(err), 8'd0);

      // Short shift: outputs hold, error set and sticky.
      do_cap("s4_cap", 3'b001);
      for (int k = 0; k < L - 1; k++) do_shf("s4_shf", 1'b0);
      do_upd("s4_upd");
      expect_val("s4_data_hold", 8'(odata), 8'h06);
      expect_val("s4_err", 8'(err), 8'd1);
      do_cap("s4_cap2", 3'b011);
      for (int k = 0; k < L; k++) do_shf("s4_shf2", 1'b1);
      do_upd("s4_upd2");
      expect_val("s4_err_sticky", 8'(err), 8'd1);

      // Deselected enables are ignored; ce+ue means capture only.
      step("s5_nosel_ce", 0, 0, 1, 0, 0, 1, 3'b000);
      step("s5_nosel_se", 0, 0, 0, 1, 0, 0, 3'b000);
      step("s5_nosel_ue", 0, 0, 0, 0, 1, 0, 3'b000);
      step("s5_ce_ue",    0, 1, 1, 0, 1, 0, 3'b100);
      step("s5_se_ue",    0, 1, 0, 1, 1, 1, 3'b100);

      // Reset mid-shift, then update without capture.
      do_rst("s6_rst_a");
      do_cap("s6_cap", 3'b111);
      do_shf("s6_shf", 1'b1);
      do_shf("s6_shf", 1'b1);
      do_rst("s6_rst");
      expect_val("s6_zero", 8'({so, osel, err}) | 8'(odata), 8'h00);
      do_upd("s6_upd");
      expect_val("s6_err", 8'(err), 8'(GUARD));

      // Counter saturation: 2^CNT_W + L shifts must still be flagged.
      do_rst("sat_rst");
      do_cap("sat_cap", 3'b010);
      for (int k = 0; k < (1 << CNT_W) + L; k++) do_shf("sat_shf", 1'b1);
      do_upd("sat_upd");
      expect_val("sat_err", 8'(err), 8'(GUARD));

      // Random traffic.
      do_rst("rnd_rst");
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 3))
            0, 1: begin
               n = L + int'($urandom_range(0, 4)) - 1;
               if ($urandom_range(0, 2) != 0) n = L;
               do_cap("rnd_cap", WIDTH'($urandom));
               for (int k = 0; k < n; k++) do_shf("rnd_shf", 1'($urandom));
               do_upd("rnd_upd");
            end
            2: begin
               for (int k = 0; k < 6; k++)
                  step("rnd_mix", 0, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                       1'($urandom), 1'($urandom), WIDTH'($urandom));
            end
            default: begin
               if ($urandom_range(0, 2) == 0) do_rst("rnd_rst");
               else step("rnd_idle", 0, 1, 0, 0, 0, 1'($urandom), WIDTH'($urandom));
            end
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
